// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Latency: none; this file holds declarations only.
// Backpressure: not applicable.
package muldiv_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    localparam logic [3:0] ALU_OP_MUL = 4'b1010;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

    // Magnitude of a two's-complement value when en is set; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude for the divider.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic en);
        return (en && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One MSB-first restoring division iteration on {rem, quo}.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when to register the result.
module div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;

    // Shift in the next dividend bit, trial-subtract, keep the difference if it did not go negative
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {2'b00, divisor_i};
        if (!trial[XLEN+1]) begin
            rem_o = trial[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: multiplies via the shared ALU, divides via a 32-step restoring divider.
// Latency: MUL* 2 cycles, div-by-zero/overflow 1 cycle, other divides 34 cycles to resp_valid.
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready; flush aborts.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [3:0]      alu_op_o,
    output logic [2:0]      alu_funct3_o,
    input  logic [XLEN-1:0] alu_result_i
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state_q;
    logic [XLEN-1:0]  a_q, b_q, resp_q, quo_q, dvs_q;
    logic [XLEN:0]    rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       funct3_q;

    logic [XLEN:0]    rem_d;
    logic [XLEN-1:0]  quo_d;

    logic             req_signed, div_zero, div_ovf;
    logic             div_signed, neg_quo, neg_rem;
    logic [XLEN-1:0]  quo_fix, rem_fix;

    // Request-side decode for the divide special cases, evaluated in IDLE
    assign req_signed = ~req_funct3_i[0];
    assign div_zero   = (req_b_i == '0);
    assign div_ovf    = req_signed && (req_a_i == INT_MIN) && (req_b_i == '1);

    // Sign restoration from the latched original operands
    assign div_signed = funct3_q[2] & ~funct3_q[0];
    assign neg_quo    = div_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign neg_rem    = div_signed & a_q[XLEN-1];
    assign quo_fix    = neg_quo ? (~quo_q + XLEN'(1)) : quo_q;
    assign rem_fix    = neg_rem ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];

    div_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    // Control outputs depend only on state; data outputs come straight from registers
    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_DONE);
    assign resp_data_o  = resp_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_op_o     = ALU_OP_MUL;
    assign alu_funct3_o = {1'b0, funct3_q[1:0]};

    // Sequencer FSM with its datapath registers; flush beats everything but reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            funct3_q <= '0;
            resp_q   <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        a_q      <= req_a_i;
                        b_q      <= req_b_i;
                        funct3_q <= req_funct3_i;
                        if (!req_funct3_i[2]) begin
                            state_q <= ST_MUL;
                        end else if (div_zero) begin
                            resp_q  <= req_funct3_i[1] ? req_a_i : '1;
                            state_q <= ST_DONE;
                        end else if (div_ovf) begin
                            resp_q  <= req_funct3_i[1] ? '0 : INT_MIN;
                            state_q <= ST_DONE;
                        end else begin
                            quo_q   <= abs_val(req_a_i, req_signed);
                            dvs_q   <= abs_val(req_b_i, req_signed);
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    resp_q  <= alu_result_i;
                    state_q <= ST_DONE;
                end
                ST_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    resp_q  <= funct3_q[1] ? rem_fix : quo_fix;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
